// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns the LSU memory stage's single-outstanding read/write request
// into one AXI4-Lite master transaction. Optional watchdog: define AXI_TIMEOUT_EN.
module lsu_axi_bridge #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_mask_i,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  input  logic                rx_r_valid_i,
  output logic                rx_r_ready_o,
  input  logic [ADDR_W-1:0]   rx_r_addr_i,
  input  logic [7:0]          rx_r_size_i,
  output logic [DATA_W-1:0]   rx_data_read_o,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                bus_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  output logic [2:0]          dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; a valid, once raised, holds with a stable payload until that edge.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    WR_DONE = 3'd3,
    RD_REQ  = 3'd4,
    RD_DATA = 3'd5,
    RD_DONE = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [2:0]          arsize_q, arsize_d;
  logic                timeout;
  logic                unused_size_bits;

  assign unused_size_bits = ^rx_r_size_i[7:3];

`ifdef AXI_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        wait_st;

  assign wait_st = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_DATA);
  // Fires in the TIMEOUT_CYCLES-th cycle spent in one waiting state.
  assign timeout = wait_st && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = 16'd0;
    if (state_d == state_q && wait_st) to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= 16'd0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_valid_i) begin
          awaddr_d  = w_addr_i;
          wdata_d   = w_data_i;
          wstrb_d   = w_mask_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (rx_r_valid_i) begin
          araddr_d = rx_r_addr_i;
          arsize_d = rx_r_size_i[2:0];
          state_d  = RD_REQ;
        end
      end
      WR_REQ: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          state_d = WR_RESP;
        end else if (timeout) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = WR_DONE;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bus_err_d = (bresp != 2'b00);
          state_d   = WR_DONE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = WR_DONE;
        end
      end
      WR_DONE: if (w_ready_i) state_d = IDLE;
      RD_REQ: begin
        if (arready) begin
          state_d = RD_DATA;
        end else if (timeout) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = RD_DONE;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d   = rdata;
          bus_err_d = (rresp != 2'b00);
          state_d   = RD_DONE;
        end else if (timeout) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = RD_DONE;
        end
      end
      RD_DONE: if (rx_data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bus_err_q <= bus_err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      rdata_q   <= rdata_d;
    end
  end

  // A write request wins over a read presented in the same IDLE cycle.
  assign w_ready_o      = (state_q == IDLE) && w_valid_i;
  assign rx_r_ready_o   = (state_q == IDLE) && rx_r_valid_i && !w_valid_i;
  assign w_valid_o      = (state_q == WR_DONE);
  assign rx_data_valid  = (state_q == RD_DONE);
  assign rx_data_read_o = rdata_q;
  assign bus_err        = bus_err_q;
  assign awvalid        = awvalid_q;
  assign awaddr         = awaddr_q;
  assign wvalid         = wvalid_q;
  assign wdata          = wdata_q;
  assign wstrb          = wstrb_q;
  assign bready         = (state_q == WR_RESP);
  assign arvalid        = (state_q == RD_REQ);
  assign araddr         = araddr_q;
  assign arsize         = arsize_q;
  assign rready         = (state_q == RD_DATA);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: scripted AXI slave with per-channel delays,
// hand-computed latencies/payloads, and a read-data expected queue.
module tb_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
  logic [63:0] w_addr_i, w_data_i;
  logic [7:0]  w_mask_i;
  logic        rx_r_valid_i, rx_r_ready_o;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic [63:0] rx_data_read_o;
  logic        rx_data_valid, rx_data_ready, bus_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [2:0]  arsize, dbg_state_o;
  logic [1:0]  bresp, rresp;

  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o), .rx_r_addr_i(rx_r_addr_i),
    .rx_r_size_i(rx_r_size_i), .rx_data_read_o(rx_data_read_o),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready), .bus_err(bus_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .dbg_state_o(dbg_state_o)
  );

  // Slave channels: each raises its signal for one cycle after <dly> cycles of trigger.
  initial begin : aw_slave
    awready = 0; aw_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || awready) begin awready = 0; aw_cnt = 0; end
      else if (awvalid) begin
        if (aw_cnt >= aw_dly) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
      end
    end
  end

  initial begin : w_slave
    wready = 0; w_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || wready) begin wready = 0; w_cnt = 0; end
      else if (wvalid) begin
        if (w_cnt >= w_dly) begin wready = 1; w_cnt = 0; end else w_cnt++;
      end
    end
  end

  initial begin : b_slave
    bvalid = 0; b_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || bvalid) begin bvalid = 0; b_cnt = 0; end
      else if (bready) begin
        if (b_cnt >= b_dly) begin bvalid = 1; b_cnt = 0; end else b_cnt++;
      end
    end
  end

  initial begin : ar_slave
    arready = 0; ar_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || arready) begin arready = 0; ar_cnt = 0; end
      else if (arvalid) begin
        if (ar_cnt >= ar_dly) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
      end
    end
  end

  initial begin : r_slave
    rvalid = 0; r_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || rvalid) begin rvalid = 0; r_cnt = 0; end
      else if (rready) begin
        if (r_cnt >= r_dly) begin rvalid = 1; r_cnt = 0; end else r_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
    if (bus_err) err_seen++;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ctl"}, {w_ready_o, rx_r_ready_o, w_valid_o, rx_data_valid, bus_err,
                          awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check({pfx, "_state"}, dbg_state_o, 64'd0);
    check({pfx, "_rdata"}, rx_data_read_o, 64'd0);
    check({pfx, "_addr"}, awaddr | araddr, 64'd0);
    check({pfx, "_wpay"}, wdata | {56'd0, wstrb}, 64'd0);
  endtask

  task automatic run_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, output logic [1:0] rdy,
                           output int lat, output int aw_cyc, output int w_cyc,
                           output int bad);
    w_valid_i = 1; w_addr_i = addr; w_data_i = data; w_mask_i = mask;
    #1 rdy = {w_ready_o, rx_r_ready_o};
    step();
    w_valid_i = 0;
    lat = 1; aw_cyc = 0; w_cyc = 0; bad = 0;
    while (!w_valid_o && lat < 400) begin
      if (awvalid) begin aw_cyc++; if (awaddr !== addr) bad++; end
      if (wvalid) begin w_cyc++; if (wdata !== data || wstrb !== mask) bad++; end
      if (arvalid || (bready && (awvalid || wvalid))) bad++;
      step(); lat++;
    end
  endtask

  task automatic run_read(input logic [63:0] addr, input logic [7:0] size,
                          output int lat, output int ar_cyc, output int bad,
                          output logic [63:0] data);
    rx_r_valid_i = 1; rx_r_addr_i = addr; rx_r_size_i = size;
    step();
    rx_r_valid_i = 0;
    lat = 1; ar_cyc = 0; bad = 0;
    while (!rx_data_valid && lat < 400) begin
      if (arvalid) begin
        ar_cyc++;
        if (araddr !== addr || arsize !== size[2:0]) bad++;
      end
      if (awvalid || wvalid) bad++;
      step(); lat++;
    end
    data = rx_data_read_o;
  endtask

  initial begin : main
    logic [1:0]  rdy;
    logic [63:0] got;
    int lat, c1, c2, bad, base, n;

    rst = 1; w_valid_i = 0; w_ready_i = 1; w_addr_i = 0; w_data_i = 0; w_mask_i = 0;
    rx_r_valid_i = 0; rx_r_addr_i = 0; rx_r_size_i = 0; rx_data_ready = 1;
    bresp = 2'b00; rresp = 2'b00; rdata = 64'd0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 0;
    step();

    // T1: zero-wait write
    base = err_seen;
    run_write(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, rdy, lat, c1, c2, bad);
    check("t1_accept_rdy", rdy, 2'b10);
    check("t1_latency", lat, 3);
    check("t1_awaddr", awaddr, 64'h8000_0008);
    check("t1_wstrb", wstrb, 8'hFF);
    check("t1_wdata", wdata, 64'h1122_3344_5566_7788);
    check("t1_payload_stable", bad, 0);
    step();
    check("t1_done_drop", w_valid_o, 1'b0);
    check("t1_no_err", err_seen - base, 0);

    // T2: read with arready after 2 stall cycles, rvalid after 4
    ar_dly = 2; r_dly = 4; rdata = 64'hDEAD_BEEF_CAFE_F00D;
    exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    run_read(64'h8000_0010, 8'hF3, lat, c1, bad, got);
    check("t2_data", got, exp_q.pop_front());
    check("t2_arvalid_cycles", c1, 3);
    check("t2_ar_stable", bad, 0);
    check("t2_arsize", arsize, 3'd3);
    check("t2_latency", lat, 9);
    step();
    ar_dly = 0; r_dly = 0;

    // T3: simultaneous write and read; write first, read on the next IDLE cycle
    rx_r_valid_i = 1; rx_r_addr_i = 64'h8000_0020; rx_r_size_i = 8'h03;
    run_write(64'h8000_0018, 64'hA5A5_0000_5A5A_FFFF, 8'h0F, rdy, lat, c1, c2, bad);
    check("t3_write_wins", rdy, 2'b10);
    check("t3_write_latency", lat, 3);
    check("t3_no_ar_overlap", bad, 0);
    check("t3_read_held_off", rx_r_ready_o, 1'b0);
    step();
    check("t3_read_ready_idle", rx_r_ready_o, 1'b1);
    rdata = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    run_read(64'h8000_0020, 8'h03, lat, c1, bad, got);
    check("t3_read_latency", lat, 3);
    check("t3_read_data", got, exp_q.pop_front());
    step();

    // T4a: awready 3 cycles ahead of wready
    aw_dly = 0; w_dly = 3;
    run_write(64'h8000_0028, 64'h0000_1111_2222_3333, 8'hF0, rdy, lat, c1, c2, bad);
    check("t4a_aw_cycles", c1, 1);
    check("t4a_w_cycles", c2, 4);
    check("t4a_order_stable", bad, 0);
    check("t4a_latency", lat, 6);
    step();

    // T4b: same-cycle AW/W handshakes, error write response
    aw_dly = 1; w_dly = 1; bresp = 2'b11; base = err_seen;
    run_write(64'h8000_0030, 64'h4444_5555_6666_7777, 8'h3C, rdy, lat, c1, c2, bad);
    check("t4b_aw_cycles", c1, 2);
    check("t4b_w_cycles", c2, 2);
    check("t4b_latency", lat, 4);
    step();
    check("t4b_berr_pulse", err_seen - base, 1);
    aw_dly = 0; w_dly = 0; bresp = 2'b00;

    // T5: SLVERR read, consumer stalls 5 cycles
    rresp = 2'b10; rx_data_ready = 0; base = err_seen; rdata = 64'hFEED_FACE_0BAD_F00D;
    exp_q.push_back(64'hFEED_FACE_0BAD_F00D);
    run_read(64'h8000_0038, 8'h03, lat, c1, bad, got);
    check("t5_data", got, exp_q[0]);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (rx_data_valid && rx_data_read_o === exp_q[0]) n++;
      if (i < 4) step();
    end
    check("t5_stall_stable", n, 5);
    void'(exp_q.pop_front());
    rx_data_ready = 1;
    step();
    check("t5_valid_drop", rx_data_valid, 1'b0);
    check("t5_rerr_one_cycle", err_seen - base, 1);
    check("t5_data_held", rx_data_read_o, 64'hFEED_FACE_0BAD_F00D);
    rresp = 2'b00;

    // T6: reset while waiting in RD_DATA
    r_dly = 20;
    rx_r_valid_i = 1; rx_r_addr_i = 64'h8000_0040; rx_r_size_i = 8'h03;
    step();
    rx_r_valid_i = 0;
    n = 0;
    while (!rready && n < 10) begin step(); n++; end
    check("t6_in_rd_data", dbg_state_o, 3'd5);
    rst = 1;
    step();
    check_idle_outputs("t6_mid_reset");
    rst = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rx_data_valid || w_valid_o || arvalid || rready) n++;
    end
    check("t6_abandoned", n, 0);
    r_dly = 0; rdata = 64'h7777_6666_5555_4444;
    run_read(64'h8000_0048, 8'h02, lat, c1, bad, got);
    check("t6_after_reset_latency", lat, 3);
    check("t6_after_reset_data", got, 64'h7777_6666_5555_4444);
    step();

`ifdef AXI_TIMEOUT_EN
    // Silent read slave: watchdog completes the read with zero data
    r_dly = 100000; base = err_seen;
    run_read(64'h8000_0050, 8'h03, lat, c1, bad, got);
    check("to_latency", lat, 258);
    check("to_data_zero", got, 64'd0);
    check("to_err_pulse", err_seen - base, 1);
    check("to_rready_drop", rready, 1'b0);
    step();
    r_dly = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
